ay_write_sequencer: RTL and testbench
=====================================

Name: ay_write_sequencer

Overview:
Sequences register writes into the ay3891x PSG core: two-phase address-latch / data-write bus cycle (a0=0 then a0=1, one wr_tick each).
Shares the PSG write port between two requesters (port 0: CPU I/O path, port 1: autonomous music/frame player) with round-robin arbitration.
Keeps a 16x8 shadow copy of PSG registers for readback and optional suppression of redundant writes.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after each data write before the next grant (0..255)
SKIP_DUP, 1, 1 = writes whose data equals a valid shadow value are acked without a bus cycle; R13 is never skipped

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 write request, level; held until ack0
addr0  input  4  port 0 PSG register number
data0  input  8  port 0 register value
ack0  output  1  one-cycle pulse: port 0 item accepted
req1  input  1  port 1 write request
addr1  input  4  port 1 register number
data1  input  8  port 1 register value
ack1  output  1  one-cycle pulse: port 1 item accepted
psg_a0  output  1  to ay3891x a0
psg_wr_tick  output  1  to ay3891x wr_tick
psg_wdata  output  8  to ay3891x wdata
busy  output  1  high whenever state != IDLE
shadow_addr  input  4  shadow readback select
shadow_data  output  8  shadow[shadow_addr], combinational

Behaviour:
- Reset (reset=0, async): state=IDLE; ack0=ack1=0; psg_a0=0, psg_wr_tick=0, psg_wdata=0; busy=0; shadow regs and valid bits cleared (shadow_data=0); last_grant=1. In-flight sequence abandoned, no partial write completed after release.
- States: IDLE, ADDR, DATA, GAP, SKIP. All outputs registered except shadow_data.
- IDLE: req sampled only here. Single req -> grant it. Both -> grant port != last_grant; update last_grant. Latch addr/data into internal regs.
- Grant edge (end of cycle N): ack of granted port high during cycle N+1 only.
- Normal write: next state ADDR (cycle N+1): psg_a0=0, psg_wdata=addr (zero-extended), psg_wr_tick=1. DATA (N+2): psg_a0=1, psg_wdata=data, psg_wr_tick=1; shadow[addr]<=data, valid[addr]<=1 at end of DATA.
- After DATA: GAP_CYCLES=0 -> IDLE (N+3, next grant possible at end of N+3); else GAP for exactly GAP_CYCLES cycles, then IDLE. Outside ADDR/DATA: psg_wr_tick=0, psg_a0=0, psg_wdata=0.
- Skip: SKIP_DUP=1, addr!=13, valid[addr]=1, shadow[addr]==data -> SKIP for one cycle (ack high, no wr_tick), then IDLE. No GAP after skip.
- R13 (envelope shape) always written: writing restarts envelope.
- Requester may change addr/data/req in the cycle ack is high; new item not sampled before state returns to IDLE, so no double acceptance.
- Throughput, GAP_CYCLES=0: one write per 3 cycles; a continuously requesting pair alternates 0,1,0,1.
- A req dropped before grant is simply not served; no ack issued.
- shadow_data reflects updates the cycle after DATA.

Test Plan:
- Reset release, req0 addr=0 data=0x21 -> ack0 one cycle after grant; next cycles: (a0=0,wdata=0x00,wr_tick=1), (a0=1,wdata=0x21,wr_tick=1); shadow[0]=0x21; busy high 2 cycles.
- req0 and req1 asserted together from reset (R1=0x0f, R8=0x0f) -> port 0 served first, then port 1; repeated simultaneous reqs alternate; each bus pair matches its data.
- SKIP_DUP=1: write R7=0xf0 twice -> second acked, no wr_tick, busy 1 cycle; write R13=0x02 twice -> both produce full bus cycles.
- GAP_CYCLES=4: back-to-back req1 writes -> exactly 4 idle cycles between DATA of first and ADDR of second; ack spacing 7 cycles.
- Assert reset low during DATA -> wr_tick/a0/wdata 0 immediately, busy=0, shadow_data=0 for all addresses; after release, pending req0 re-granted with full bus cycle.
- Sweep shadow_addr 0..15 after writing 0x10..0x1f to R0..R15 -> shadow_data returns matching value each.

Source files
------------

// File: rtl/ay_write_sequencer.sv
// ay_write_sequencer
// Two-port round-robin write sequencer for the ay3891x PSG write port.
// Each accepted item becomes an address-latch cycle (a0=0) followed by a
// data-write cycle (a0=1), optionally followed by a fixed idle gap.
// A 16x8 shadow of the PSG registers supports readback and lets repeated
// identical writes be acknowledged without touching the bus (R13 excluded,
// since rewriting the envelope shape restarts the envelope).

module ay_write_sequencer #(
   parameter int GAP_CYCLES = 0,
   parameter bit SKIP_DUP   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [3:0] addr0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [3:0] addr1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       psg_a0,
   output logic       psg_wr_tick,
   output logic [7:0] psg_wdata,
   output logic       busy,
   input  logic [3:0] shadow_addr,
   output logic [7:0] shadow_data
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_GAP  = 3'd3,
      S_SKIP = 3'd4
   } state_t;

   // Gap counter counts down to zero, so it is loaded with one less than the gap length
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_last_grant;
   logic [3:0]  r_addr;
   logic [7:0]  r_data;
   logic [7:0]  r_gap_cnt;
   logic [7:0]  r_shadow [16];
   logic [15:0] r_valid;

   logic        w_any;
   logic        w_sel;
   logic [3:0]  w_sel_addr;
   logic [7:0]  w_sel_data;
   logic        w_skip;
   logic [3:0]  w_cur_addr;
   logic [7:0]  w_cur_data;

   logic        w_ack0_next;
   logic        w_ack1_next;
   logic        w_a0_next;
   logic        w_tick_next;
   logic [7:0]  w_wdata_next;
   logic        w_busy_next;

   // Arbitration: a lone requester wins outright, a tie goes to the port not served last
   always_comb begin
      w_any = req0 | req1;
      if (req0 && req1) begin
         w_sel = ~r_last_grant;
      end else begin
         w_sel = req1;
      end
      w_sel_addr = w_sel ? addr1 : addr0;
      w_sel_data = w_sel ? data1 : data0;
      w_skip     = SKIP_DUP && (w_sel_addr != 4'd13) && r_valid[w_sel_addr] &&
                   (r_shadow[w_sel_addr] == w_sel_data);
      // At the grant edge the item registers are not yet loaded, so look through to the mux
      w_cur_addr = (r_state == S_IDLE) ? w_sel_addr : r_addr;
      w_cur_data = (r_state == S_IDLE) ? w_sel_data : r_data;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_next = w_skip ? S_SKIP : S_ADDR;
            end
         end
         S_ADDR: w_state_next = S_DATA;
         S_DATA: w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP: begin
            if (r_gap_cnt == 8'd0) begin
               w_state_next = S_IDLE;
            end
         end
         S_SKIP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state, so every bus output can be registered
   always_comb begin
      w_ack0_next  = 1'b0;
      w_ack1_next  = 1'b0;
      w_a0_next    = 1'b0;
      w_tick_next  = 1'b0;
      w_wdata_next = 8'd0;
      w_busy_next  = (w_state_next != S_IDLE);
      if ((r_state == S_IDLE) && w_any) begin
         w_ack0_next = ~w_sel;
         w_ack1_next = w_sel;
      end
      case (w_state_next)
         S_ADDR: begin
            w_tick_next  = 1'b1;
            w_wdata_next = {4'h0, w_cur_addr};
         end
         S_DATA: begin
            w_a0_next    = 1'b1;
            w_tick_next  = 1'b1;
            w_wdata_next = w_cur_data;
         end
         default: ;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         psg_a0      <= 1'b0;
         psg_wr_tick <= 1'b0;
         psg_wdata   <= 8'd0;
         busy        <= 1'b0;
      end else begin
         ack0        <= w_ack0_next;
         ack1        <= w_ack1_next;
         psg_a0      <= w_a0_next;
         psg_wr_tick <= w_tick_next;
         psg_wdata   <= w_wdata_next;
         busy        <= w_busy_next;
      end
   end

   // Item capture at grant, round-robin pointer, and gap countdown
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant <= 1'b1;
         r_addr       <= 4'd0;
         r_data       <= 8'd0;
         r_gap_cnt    <= 8'd0;
      end else begin
         if ((r_state == S_IDLE) && w_any) begin
            r_last_grant <= w_sel;
            r_addr       <= w_sel_addr;
            r_data       <= w_sel_data;
         end
         if (r_state == S_DATA) begin
            r_gap_cnt <= GAP_LOAD;
         end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
         end
      end
   end

   // Shadow copy is committed at the end of the data-write cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            r_shadow[i] <= 8'd0;
         end
         r_valid <= 16'd0;
      end else if (r_state == S_DATA) begin
         r_shadow[r_addr] <= r_data;
         r_valid[r_addr]  <= 1'b1;
      end
   end

   assign shadow_data = r_shadow[shadow_addr];

endmodule

// File: tb/tb_ay_write_sequencer.sv
// Directed testbench for ay_write_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are read at that
// same point, i.e. they show the values registered at the preceding edge.

module tb_ay_write_sequencer;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [3:0] addr0, addr1;
   logic [7:0] data0, data1;
   logic       ack0, ack1;
   logic       psg_a0, psg_wr_tick;
   logic [7:0] psg_wdata;
   logic       busy;
   logic [3:0] shadow_addr;
   logic [7:0] shadow_data;

   logic       g_req0, g_req1;
   logic [3:0] g_addr0, g_addr1;
   logic [7:0] g_data0, g_data1;
   logic       g_ack0, g_ack1;
   logic       g_a0, g_tick;
   logic [7:0] g_wdata;
   logic       g_busy;
   logic [3:0] g_shadow_addr;
   logic [7:0] g_shadow_data;

   int n_cmp = 0;
   int n_err = 0;

   ay_write_sequencer #(.GAP_CYCLES(0), .SKIP_DUP(1'b1)) dut (
      .clk(clk), .reset(rst_n),
      .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
      .psg_a0(psg_a0), .psg_wr_tick(psg_wr_tick), .psg_wdata(psg_wdata),
      .busy(busy), .shadow_addr(shadow_addr), .shadow_data(shadow_data)
   );

   ay_write_sequencer #(.GAP_CYCLES(4), .SKIP_DUP(1'b1)) dut_gap (
      .clk(clk), .reset(rst_n),
      .req0(g_req0), .addr0(g_addr0), .data0(g_data0), .ack0(g_ack0),
      .req1(g_req1), .addr1(g_addr1), .data1(g_data1), .ack1(g_ack1),
      .psg_a0(g_a0), .psg_wr_tick(g_tick), .psg_wdata(g_wdata),
      .busy(g_busy), .shadow_addr(g_shadow_addr), .shadow_data(g_shadow_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Called in an IDLE cycle with requests already driven; checks one full
   // address/data bus pair for the expected port, drops that port's request,
   // and returns in the following IDLE cycle.
   task automatic serve(input int port, input logic [3:0] a, input logic [7:0] d);
      tick();
      check($sformatf("p%0d R%0d addr-cycle ack", port, a),
            32'({ack1, ack0}), (port == 0) ? 32'h1 : 32'h2);
      check($sformatf("p%0d R%0d addr-cycle bus", port, a),
            32'({busy, psg_wr_tick, psg_a0, psg_wdata}), 32'({3'b110, 4'h0, a}));
      if (port == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      check($sformatf("p%0d R%0d data-cycle bus", port, a),
            32'({ack1, ack0, busy, psg_wr_tick, psg_a0, psg_wdata}), 32'({2'b00, 3'b111, d}));
      tick();
      check($sformatf("p%0d R%0d idle after", port, a),
            32'({busy, psg_wr_tick, psg_a0, psg_wdata}), 32'h0);
   endtask

   initial begin
      int cnt;
      int gapcnt;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
      g_req0 = 0; g_req1 = 0; g_addr0 = 0; g_addr1 = 0; g_data0 = 0; g_data1 = 0;
      shadow_addr = 0; g_shadow_addr = 0;
      tick();
      tick();

      // Reset state
      check("reset outputs", 32'({ack0, ack1, psg_a0, psg_wr_tick, busy, psg_wdata}), 32'h0);
      check("reset shadow", 32'(shadow_data), 32'h0);
      rst_n = 1'b1;

      // Single write R0=0x21
      req0 = 1; addr0 = 4'd0; data0 = 8'h21;
      serve(0, 4'd0, 8'h21);
      shadow_addr = 4'd0; #1;
      check("shadow R0", 32'(shadow_data), 32'h21);

      // Simultaneous requests from reset, then a continuously requesting pair
      do_reset();
      req0 = 1; addr0 = 4'd1; data0 = 8'h0f;
      req1 = 1; addr1 = 4'd8; data1 = 8'h0f;
      serve(0, 4'd1, 8'h0f);
      req0 = 1; addr0 = 4'd2; data0 = 8'h33;
      serve(1, 4'd8, 8'h0f);
      req1 = 1; addr1 = 4'd9; data1 = 8'h44;
      serve(0, 4'd2, 8'h33);
      serve(1, 4'd9, 8'h44);
      shadow_addr = 4'd8; #1;
      check("shadow R8", 32'(shadow_data), 32'h0f);

      // Duplicate suppression
      req0 = 1; addr0 = 4'd7; data0 = 8'hf0;
      serve(0, 4'd7, 8'hf0);
      req0 = 1;
      tick();
      check("skip ack/busy/tick", 32'({ack0, ack1, busy, psg_wr_tick, psg_a0}), 32'b10100);
      req0 = 0;
      tick();
      check("skip back to idle", 32'({ack0, busy, psg_wr_tick}), 32'h0);
      req0 = 1; addr0 = 4'd13; data0 = 8'h02;
      serve(0, 4'd13, 8'h02);
      req0 = 1;
      serve(0, 4'd13, 8'h02);

      // Gap of 4: back-to-back port 1 items on the gapped instance
      g_req1 = 1; g_addr1 = 4'd3; g_data1 = 8'h55;
      tick();
      check("gap first ack", 32'({g_ack1, g_tick, g_wdata}), 32'({2'b11, 8'h03}));
      g_addr1 = 4'd4; g_data1 = 8'h66;
      cnt = 0;
      gapcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (g_ack1) begin
            cnt = i;
            break;
         end
         if (g_busy && !g_tick) gapcnt++;
      end
      check("gap ack spacing", 32'(cnt), 32'd7);
      check("gap cycle count", 32'(gapcnt), 32'd4);
      check("gap second addr", 32'({g_tick, g_a0, g_wdata}), 32'({2'b10, 8'h04}));
      g_req1 = 0;
      tick();
      check("gap second data", 32'({g_tick, g_a0, g_wdata}), 32'({2'b11, 8'h66}));

      // Reset asserted during the data cycle
      req0 = 1; addr0 = 4'd5; data0 = 8'h77;
      tick();
      tick();
      check("pre-reset data cycle", 32'({psg_wr_tick, psg_a0, psg_wdata}), 32'({2'b11, 8'h77}));
      rst_n = 1'b0;
      #1;
      check("async reset bus", 32'({ack0, busy, psg_wr_tick, psg_a0, psg_wdata}), 32'h0);
      for (int i = 0; i < 16; i++) begin
         shadow_addr = 4'(i);
         #1;
         check($sformatf("reset shadow R%0d", i), 32'(shadow_data), 32'h0);
      end
      tick();
      rst_n = 1'b1;
      serve(0, 4'd5, 8'h77);

      // Fill every register and sweep the readback port
      for (int i = 0; i < 16; i++) begin
         req0 = 1; addr0 = 4'(i); data0 = 8'(8'h10 + i);
         serve(0, 4'(i), 8'(8'h10 + i));
      end
      for (int i = 0; i < 16; i++) begin
         shadow_addr = 4'(i);
         #1;
         check($sformatf("sweep shadow R%0d", i), 32'(shadow_data), 32'(8'h10 + i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
